fifo_requester: RTL and testbench
=================================

FIFO_REQUESTER -- requirements
Module: fifo_requester

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, FIFO data width.
REQ-002 The block SHALL have parameter STALL_MAX, default 15, maximum consecutive cycles spent waiting on full/empty before aborting.
REQ-003 The block SHALL have one clock and a synchronous, active-low reset.
REQ-004 The block SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-005 The block SHALL have port reset_n, input, 1 bit: synchronous active-low reset.
REQ-006 The block SHALL have port start, input, 1 bit: burst command strobe, sampled only in IDLE.
REQ-007 The block SHALL have port op, input, 1 bit: burst direction, 0 = write burst, 1 = read burst; latched with start.
REQ-008 The block SHALL have port len, input, 4 bits: number of words in the burst; latched with start.
REQ-009 The block SHALL have port seed, input, DATA_W bits: first write word; latched with start.
REQ-010 The block SHALL have ports full and empty, input, 1 bit each: FIFO status flags.
REQ-011 The block SHALL have ports wr_ack, wr_err, rd_ack and rd_err, input, 1 bit each: FIFO handshake responses.
REQ-012 The block SHALL have port rd_data, input, DATA_W bits: FIFO read data, valid while rd_ack=1.
REQ-013 The block SHALL have ports wr_en and rd_en, output, 1 bit each: FIFO request strobes.
REQ-014 The block SHALL have port wr_data, output, DATA_W bits: write word presented with wr_en.
REQ-015 The block SHALL have ports busy, done and err, output, 1 bit each: busy while a burst is active; done pulses for 1 cycle at burst end; err is held until the next accepted start.
REQ-016 The block SHALL have port xfer_cnt, output, 4 bits: words acknowledged in the current or last burst.
REQ-017 The block SHALL have port checksum, output, DATA_W bits: modulo-2^DATA_W sum of words read in the current or last read burst.

Function
REQ-018 The FSM SHALL have states IDLE, REQ, WAIT and DONE, all registered.
REQ-019 In IDLE with start=1, the block SHALL latch op, len and seed, clear xfer_cnt, err and checksum, and go to REQ; if len=0 it SHALL go directly to DONE.
REQ-020 In REQ, if the blocking flag is set (full for a write burst, empty for a read burst), the block SHALL hold all strobes at 0, increment the stall counter, and abort to DONE with err=1 once the counter reaches STALL_MAX.
REQ-021 In REQ, if the blocking flag is clear, the block SHALL assert wr_en (with wr_data = seed + xfer_cnt, wrapping) or rd_en for exactly 1 cycle, clear the stall counter, and go to WAIT.
REQ-022 In WAIT, the block SHALL sample the response 1 cycle after the strobe.
REQ-023 In WAIT, on the matching ack the block SHALL increment xfer_cnt and, for a read, add rd_data to checksum; it SHALL then go to DONE if xfer_cnt+1 equals len, else to REQ.
REQ-024 In WAIT, on the matching error, no response, or both ack and err at once, the block SHALL treat the result as an error and handle it per REQ-030/REQ-031.
REQ-025 In WAIT, responses for the other direction SHALL be ignored.
REQ-026 In DONE, the block SHALL assert done for 1 cycle and return to IDLE; busy SHALL be 1 in REQ and WAIT only.
REQ-027 A start asserted outside IDLE SHALL be ignored.
REQ-028 wr_en and rd_en SHALL never be asserted together and SHALL never be asserted in consecutive cycles.

Reset
REQ-029 When reset_n=0 at a clock edge, the block SHALL go to IDLE and set wr_en, rd_en, busy, done, err, xfer_cnt, checksum, wr_data and the stall counter to 0, including mid-burst; no strobe SHALL be issued on the following cycle.

Configuration
REQ-030 With macro FIFO_REQ_RETRY_EN defined, an error in WAIT SHALL return the block to REQ to reissue the same word (same wr_data), up to 3 retries per word; a 4th error SHALL abort to DONE with err=1; the retry counter SHALL be cleared on each ack.
REQ-031 Without FIFO_REQ_RETRY_EN, any error in WAIT SHALL abort immediately to DONE with err=1.

Verification
REQ-032 The bench SHALL cover: write burst len=3, seed=0x10, FIFO always acks -> wr_data 0x10, 0x11, 0x12 on alternate cycles; done pulses; xfer_cnt=3; err=0.
REQ-033 The bench SHALL cover: read burst len=2, rd_data 0x5 then 0xA with rd_ack -> checksum=0xF; xfer_cnt=2; err=0.
REQ-034 The bench SHALL cover: write burst len=4 with full held at 1 -> no wr_en for 15 cycles, then done with err=1 and xfer_cnt=0.
REQ-035 The bench SHALL cover: wr_err returned on the 2nd word -> without the macro, done with err=1 and xfer_cnt=1; with the macro, the word is reissued and the burst completes if the next response is wr_ack.
REQ-036 The bench SHALL cover: reset_n=0 during WAIT of a len=5 burst -> next cycle busy=0, wr_en=0 and xfer_cnt=0.
REQ-037 The bench SHALL cover: start with len=0 -> done 2 cycles after start, no strobes, err=0.

Source files
------------

// File: rtl/fifo_requester.sv
// fifo_requester
// Issues bursts of single-word requests to a FIFO and checks each handshake.
// A write burst pushes seed, seed+1, ... and a read burst pops words and sums them.
// Each word is one request strobe followed by one response cycle, so strobes are
// never back-to-back. Waiting on full/empty is bounded by STALL_MAX.
//
// Optional feature macro: FIFO_REQ_RETRY_EN
//   When defined, a failed response reissues the same word up to 3 times
//   before the burst aborts. When undefined, the first failure aborts.
//
// Parameters
//   DATA_W    : FIFO data width
//   STALL_MAX : consecutive blocked cycles tolerated before aborting
//
// Ports
//   clk, reset_n                 : clock, synchronous active-low reset
//   start, op, len, seed         : burst command (op 0 = write, 1 = read)
//   full, empty                  : FIFO status flags
//   wr_ack, wr_err, rd_ack,
//   rd_err, rd_data              : FIFO responses, one cycle after the strobe
//   wr_en, rd_en, wr_data        : FIFO request strobes and write word
//   busy, done, err              : burst status
//   xfer_cnt, checksum           : words acknowledged, sum of words read
module fifo_requester #(
  parameter int DATA_W    = 32,
  parameter int STALL_MAX = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              op,
  input  logic [3:0]        len,
  input  logic [DATA_W-1:0] seed,
  input  logic              full,
  input  logic              empty,
  input  logic              wr_ack,
  input  logic              wr_err,
  input  logic              rd_ack,
  input  logic              rd_err,
  input  logic [DATA_W-1:0] rd_data,
  output logic              wr_en,
  output logic              rd_en,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [3:0]        xfer_cnt,
  output logic [DATA_W-1:0] checksum
);

  // The stall counter only needs to reach STALL_MAX-1: the blocked cycle that
  // would make it STALL_MAX is the one that aborts.
  localparam int SW = (STALL_MAX < 3) ? 1 : $clog2(STALL_MAX);
  localparam logic [SW-1:0] STALL_LAST = SW'(STALL_MAX - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state;
  logic              op_q;
  logic [3:0]        len_q;
  logic [DATA_W-1:0] seed_q;
  logic [SW-1:0]     stall_cnt;
`ifdef FIFO_REQ_RETRY_EN
  logic [1:0]        retry_cnt;
`endif

  logic blocked;
  logic resp_ok;

  // Only the flag and responses of the latched direction matter; a response
  // carrying both ack and err counts as a failure.
  assign blocked = op_q ? empty : full;
  assign resp_ok = op_q ? (rd_ack & ~rd_err) : (wr_ack & ~wr_err);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      op_q      <= 1'b0;
      len_q     <= 4'd0;
      seed_q    <= '0;
      stall_cnt <= '0;
      wr_en     <= 1'b0;
      rd_en     <= 1'b0;
      wr_data   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      xfer_cnt  <= 4'd0;
      checksum  <= '0;
`ifdef FIFO_REQ_RETRY_EN
      retry_cnt <= 2'd0;
`endif
    end else begin
      wr_en <= 1'b0;
      rd_en <= 1'b0;
      done  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q      <= op;
            len_q     <= len;
            seed_q    <= seed;
            xfer_cnt  <= 4'd0;
            err       <= 1'b0;
            checksum  <= '0;
            stall_cnt <= '0;
`ifdef FIFO_REQ_RETRY_EN
            retry_cnt <= 2'd0;
`endif
            if (len == 4'd0) begin
              state <= S_DONE;
            end else begin
              busy  <= 1'b1;
              state <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (blocked) begin
            if (stall_cnt == STALL_LAST) begin
              err   <= 1'b1;
              busy  <= 1'b0;
              state <= S_DONE;
            end else begin
              stall_cnt <= stall_cnt + 1'b1;
            end
          end else begin
            stall_cnt <= '0;
            if (op_q) begin
              rd_en <= 1'b1;
            end else begin
              wr_en   <= 1'b1;
              wr_data <= seed_q + DATA_W'(xfer_cnt);
            end
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (resp_ok) begin
            xfer_cnt <= xfer_cnt + 4'd1;
            if (op_q) begin
              checksum <= checksum + rd_data;
            end
`ifdef FIFO_REQ_RETRY_EN
            retry_cnt <= 2'd0;
`endif
            if (xfer_cnt + 4'd1 == len_q) begin
              busy  <= 1'b0;
              state <= S_DONE;
            end else begin
              state <= S_REQ;
            end
          end else begin
`ifdef FIFO_REQ_RETRY_EN
            // xfer_cnt is unchanged, so the reissue carries the same word.
            if (retry_cnt != 2'd3) begin
              retry_cnt <= retry_cnt + 2'd1;
              state     <= S_REQ;
            end else begin
              err   <= 1'b1;
              busy  <= 1'b0;
              state <= S_DONE;
            end
`else
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= S_DONE;
`endif
          end
        end
        S_DONE: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_requester.sv
// tb_fifo_requester
// Drives fifo_requester with directed bursts followed by randomized traffic
// (random commands, flags, responses and resets) and checks every cycle against
// a burst-level reference model, plus literal expectations for the named cases.
module tb_fifo_requester;

  localparam int DW = 32;
  localparam int SMAX = 15;
`ifdef FIFO_REQ_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n, start, op;
  logic [3:0] len;
  logic [DW-1:0] seed;
  logic full, empty, wr_ack, wr_err, rd_ack, rd_err;
  logic [DW-1:0] rd_data;
  logic wr_en, rd_en, busy, done, err;
  logic [DW-1:0] wr_data, checksum;
  logic [3:0] xfer_cnt;

  fifo_requester #(.DATA_W(DW), .STALL_MAX(SMAX)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .len(len), .seed(seed),
    .full(full), .empty(empty), .wr_ack(wr_ack), .wr_err(wr_err),
    .rd_ack(rd_ack), .rd_err(rd_err), .rd_data(rd_data),
    .wr_en(wr_en), .rd_en(rd_en), .wr_data(wr_data), .busy(busy), .done(done),
    .err(err), .xfer_cnt(xfer_cnt), .checksum(checksum)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // FIFO side: flag_mode 0 = flags low, 1 = flags high, 2 = high 1/4, 3 = high 7/8.
  int flag_mode = 0;
  bit rand_resp = 1'b0;
  int err_at = 0;
  int strobe_no = 0;
  logic [DW-1:0] rd_q[$];

  always @(posedge clk) begin
    int k;
    bit a, e;
    #1;
    wr_ack = 1'b0; wr_err = 1'b0; rd_ack = 1'b0; rd_err = 1'b0;
    case (flag_mode)
      0: begin full = 1'b0; empty = 1'b0; end
      1: begin full = 1'b1; empty = 1'b1; end
      2: begin full = ($urandom_range(0, 3) == 0); empty = ($urandom_range(0, 3) == 0); end
      default: begin full = ($urandom_range(0, 7) != 0); empty = ($urandom_range(0, 7) != 0); end
    endcase
    if (wr_en || rd_en) begin
      strobe_no++;
      if (rand_resp) k = $urandom_range(0, 7);
      else k = (strobe_no == err_at) ? 4 : 0;
      // 0-3,7 ack; 4 err; 5 silent; 6 ack+err
      a = (k < 4) || (k == 6) || (k == 7);
      e = (k == 4) || (k == 6);
      if (wr_en) begin
        wr_ack = a; wr_err = e;
        if (rand_resp) begin rd_ack = $urandom_range(0, 1); rd_err = $urandom_range(0, 1); end
      end else begin
        rd_ack = a; rd_err = e;
        if (rand_resp) begin wr_ack = $urandom_range(0, 1); wr_err = $urandom_range(0, 1); end
      end
      rd_data = (rd_q.size() != 0) ? rd_q.pop_front() : DW'($urandom);
    end else if (rand_resp) begin
      wr_ack = $urandom_range(0, 1); wr_err = $urandom_range(0, 1);
      rd_ack = $urandom_range(0, 1); rd_err = $urandom_range(0, 1);
      rd_data = DW'($urandom);
    end
  end

  // Reference model: walks each burst word by word. Expected outputs are set
  // right after each rising edge and describe the cycle that follows it.
  logic exp_wr_en, exp_rd_en, exp_busy, exp_done, exp_err;
  logic [3:0] exp_xfer;
  logic [DW-1:0] exp_wr_data, exp_cks;
  bit model_live = 1'b0;

  task automatic m_tick(output bit rst_seen);
    @(posedge clk);
    exp_wr_en = 1'b0; exp_rd_en = 1'b0; exp_done = 1'b0;
    rst_seen = !reset_n;
    if (rst_seen) begin
      exp_busy = 1'b0; exp_err = 1'b0; exp_xfer = 4'd0; exp_cks = '0; exp_wr_data = '0;
      model_live = 1'b1;
    end
  endtask

  task automatic m_burst();
    bit rs, o, blk, ack, er;
    logic [3:0] l;
    logic [DW-1:0] s;
    int w, stalls, retries;
    o = op; l = len; s = seed;
    exp_xfer = 4'd0; exp_cks = '0; exp_err = 1'b0; exp_busy = (l != 4'd0);
    w = 0; stalls = 0; retries = 0;
    while (exp_busy) begin
      m_tick(rs); if (rs) return;
      blk = o ? empty : full;
      if (blk) begin
        stalls++;
        if (stalls == SMAX) begin exp_busy = 1'b0; exp_err = 1'b1; end
      end else begin
        stalls = 0;
        if (o) exp_rd_en = 1'b1;
        else begin exp_wr_en = 1'b1; exp_wr_data = s + DW'(w); end
        m_tick(rs); if (rs) return;
        ack = o ? rd_ack : wr_ack;
        er  = o ? rd_err : wr_err;
        if (ack && !er) begin
          exp_xfer = exp_xfer + 4'd1;
          if (o) exp_cks = exp_cks + rd_data;
          w++; retries = 0;
          if (w == int'(l)) exp_busy = 1'b0;
        end else if (RETRY && retries < 3) begin
          retries++;
        end else begin
          exp_busy = 1'b0; exp_err = 1'b1;
        end
      end
    end
    m_tick(rs); if (rs) return;
    exp_done = 1'b1;
  endtask

  initial begin
    bit rs;
    exp_wr_en = 0; exp_rd_en = 0; exp_busy = 0; exp_done = 0; exp_err = 0;
    exp_xfer = 0; exp_wr_data = 0; exp_cks = 0;
    forever begin
      m_tick(rs);
      if (!rs && model_live && start) m_burst();
    end
  end

  // Per-cycle comparison plus logs for the directed literal checks.
  logic [DW-1:0] wr_log[$];
  int wr_cyc[$];
  int rd_cnt = 0;
  int busy_cyc = 0;
  logic prev_strobe = 1'b0;

  always @(negedge clk) begin
    if (model_live) begin
      chk("wr_en", wr_en, exp_wr_en);
      chk("rd_en", rd_en, exp_rd_en);
      chk("busy", busy, exp_busy);
      chk("done", done, exp_done);
      chk("err", err, exp_err);
      chk("xfer_cnt", xfer_cnt, exp_xfer);
      chk("checksum", checksum, exp_cks);
      if (exp_wr_en) chk("wr_data", wr_data, exp_wr_data);
      chk("strobe_excl", wr_en & rd_en, 0);
      chk("strobe_gap", prev_strobe & (wr_en | rd_en), 0);
      prev_strobe = wr_en | rd_en;
      if (wr_en) begin wr_log.push_back(wr_data); wr_cyc.push_back(cyc); end
      if (rd_en) rd_cnt++;
      if (busy) busy_cyc++;
    end
  end

  task automatic clear_logs();
    @(posedge clk); #2;
    wr_log.delete(); wr_cyc.delete(); rd_cnt = 0; busy_cyc = 0; strobe_no = 0;
  endtask

  task automatic run_burst(input bit o, input logic [3:0] l, input logic [DW-1:0] s,
                           output int start_cyc, output int done_cyc);
    bit seen;
    @(negedge clk);
    start = 1'b1; op = o; len = l; seed = s; start_cyc = cyc;
    @(negedge clk);
    start = 1'b0; op = ~o; len = 4'($urandom); seed = DW'($urandom);
    seen = 1'b0; done_cyc = -1;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk); #2;
      if (done === 1'b1) begin seen = 1'b1; done_cyc = cyc; end
    end
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  initial begin
    int sc, dc, n;
    reset_n = 1'b0; start = 1'b0; op = 1'b0; len = 4'd0; seed = '0;
    full = 1'b0; empty = 1'b0; wr_ack = 1'b0; wr_err = 1'b0;
    rd_ack = 1'b0; rd_err = 1'b0; rd_data = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_err", err, 0);
    chk("rst_xfer", xfer_cnt, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_checksum", checksum, 0);
    @(negedge clk) reset_n = 1'b1;

    // Write burst, len 3, seed 0x10, always acked.
    clear_logs();
    run_burst(1'b0, 4'd3, 32'h10, sc, dc);
    chk("w3_count", wr_log.size(), 3);
    if (wr_log.size() == 3) begin
      chk("w3_word0", wr_log[0], 32'h10);
      chk("w3_word1", wr_log[1], 32'h11);
      chk("w3_word2", wr_log[2], 32'h12);
      chk("w3_gap01", wr_cyc[1] - wr_cyc[0], 2);
      chk("w3_gap12", wr_cyc[2] - wr_cyc[1], 2);
    end
    chk("w3_xfer", xfer_cnt, 3);
    chk("w3_err", err, 0);

    // Read burst, len 2, data 0x5 then 0xA.
    clear_logs();
    rd_q.push_back(32'h5); rd_q.push_back(32'hA);
    run_burst(1'b1, 4'd2, 32'h0, sc, dc);
    chk("r2_count", rd_cnt, 2);
    chk("r2_checksum", checksum, 32'hF);
    chk("r2_xfer", xfer_cnt, 2);
    chk("r2_err", err, 0);

    // Write burst against a permanently full FIFO.
    clear_logs();
    flag_mode = 1;
    run_burst(1'b0, 4'd4, 32'h0, sc, dc);
    chk("stall_wr_count", wr_log.size(), 0);
    chk("stall_busy_cycles", busy_cyc, 15);
    chk("stall_err", err, 1);
    chk("stall_xfer", xfer_cnt, 0);
    flag_mode = 0;

    // Second word answered with wr_err.
    clear_logs();
    err_at = 2;
    run_burst(1'b0, 4'd3, 32'h20, sc, dc);
`ifdef FIFO_REQ_RETRY_EN
    chk("werr_err", err, 0);
    chk("werr_xfer", xfer_cnt, 3);
    chk("werr_count", wr_log.size(), 4);
    if (wr_log.size() == 4) begin
      chk("werr_first", wr_log[1], 32'h21);
      chk("werr_reissue", wr_log[2], 32'h21);
      chk("werr_last", wr_log[3], 32'h22);
    end
`else
    chk("werr_err", err, 1);
    chk("werr_xfer", xfer_cnt, 1);
    chk("werr_count", wr_log.size(), 2);
`endif
    err_at = 0;

    // Zero-length burst.
    clear_logs();
    run_burst(1'b0, 4'd0, 32'h0, sc, dc);
    chk("len0_latency", dc - sc, 2);
    chk("len0_strobes", wr_log.size() + rd_cnt, 0);
    chk("len0_err", err, 0);

    // Reset while waiting on the third word of a len-5 write burst.
    clear_logs();
    @(negedge clk);
    start = 1'b1; op = 1'b0; len = 4'd5; seed = 32'h40;
    @(negedge clk) start = 1'b0;
    n = 0;
    for (int i = 0; i < 100 && n < 3; i++) begin
      @(posedge clk); #2;
      if (wr_en === 1'b1) n++;
    end
    if (n < 3) chk("rst_mid_timeout", n, 3);
    chk("rst_mid_pre_xfer", xfer_cnt, 2);
    @(negedge clk) reset_n = 1'b0;
    @(posedge clk); #2;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_wr_en", wr_en, 0);
    chk("rst_mid_xfer", xfer_cnt, 0);
    @(negedge clk) reset_n = 1'b1;

    // Randomized traffic: commands, flags, responses, occasional resets.
    rand_resp = 1'b1;
    for (int ph = 0; ph < 2; ph++) begin
      flag_mode = (ph == 0) ? 2 : 3;
      for (int i = 0; i < 2000; i++) begin
        @(negedge clk);
        reset_n = ($urandom_range(0, 299) != 0);
        start = ($urandom_range(0, 5) == 0);
        op = 1'($urandom_range(0, 1));
        len = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 4));
        seed = DW'($urandom);
      end
    end
    @(negedge clk);
    reset_n = 1'b1; start = 1'b0;
    repeat (60) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
